// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Write-back arbiter in front of the 32x32 register set. It merges
//             the single-cycle ALU path with a FIFO-buffered load/mult path.
//             It emits one registered one-hot write per cycle, keeps
//             write-after-write ordering and bounds starvation of the FIFO.
//  Options  : WB_BYPASS_EN adds a combinational read-bypass port.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8,
    parameter int DATA_W       = 32
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic                   alu_we,
    input  logic [4:0]             alu_addr,
    input  logic [DATA_W-1:0]      alu_data,
    output logic                   alu_stall,
    input  logic                   ld_valid,
    output logic                   ld_ready,
    input  logic [4:0]             ld_addr,
    input  logic [DATA_W-1:0]      ld_data,
`ifdef WB_BYPASS_EN
    input  logic [4:0]             byp_addr,
    output logic                   byp_hit,
    output logic [DATA_W-1:0]      byp_data,
`endif
    output logic [31:0]            rf_en,
    output logic [DATA_W-1:0]      rf_d,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_SW = $clog2(STARVE_LIMIT + 1);

    // FIFO storage; r_vld is cleared in place when a newer ALU write supersedes an entry
    logic                r_vld  [DEPTH];
    logic [4:0]          r_addr [DEPTH];
    logic [DATA_W-1:0]   r_data [DEPTH];
    logic [c_PW-1:0]     r_wptr;
    logic [c_PW-1:0]     r_rptr;
    logic [c_CW-1:0]     r_count;
    logic [c_SW-1:0]     r_starve;
    logic [31:0]         r_rf_en;
    logic [DATA_W-1:0]   r_rf_d;

    logic                w_empty;
    logic                w_push;
    logic                w_push_vld;
    logic                w_pop;
    logic                w_alu_acc;
    logic                w_alu_kill;
    logic                w_wr;
    logic [4:0]          w_wr_addr;
    logic [DATA_W-1:0]   w_wr_data;
    logic [c_SW-1:0]     w_starve_nxt;

    assign w_empty    = (r_count == '0);
    assign ld_ready   = (r_count != c_CW'(DEPTH));
    assign alu_stall  = (r_starve == c_SW'(STARVE_LIMIT));
    assign fifo_count = r_count;
    assign rf_en      = r_rf_en;
    assign rf_d       = r_rf_d;

    // Source selection: forced FIFO service, then ALU, then FIFO when idle
    always_comb begin
        w_push       = ld_valid && ld_ready;
        w_alu_acc    = alu_we && !alu_stall;
        w_alu_kill   = w_alu_acc && (alu_addr != 5'd0);
        w_pop        = 1'b0;
        w_wr         = 1'b0;
        w_wr_addr    = alu_addr;
        w_wr_data    = alu_data;
        w_starve_nxt = r_starve;
        // A same-cycle enqueue to the ALU's target is already stale
        w_push_vld   = (ld_addr != 5'd0) && !(w_alu_kill && (ld_addr == alu_addr));

        if (alu_stall) begin
            w_pop = !w_empty;
        end else if (alu_we) begin
            w_wr = (alu_addr != 5'd0);
        end else begin
            w_pop = !w_empty;
        end

        if (w_pop) begin
            w_wr      = r_vld[r_rptr];
            w_wr_addr = r_addr[r_rptr];
            w_wr_data = r_data[r_rptr];
        end

        if (w_pop || w_empty) begin
            w_starve_nxt = '0;
        end else if (!alu_stall) begin
            w_starve_nxt = r_starve + 1'b1;
        end
    end

    // FIFO entry storage with WAW invalidation of matching queued entries
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_vld[i]  <= 1'b0;
                r_addr[i] <= '0;
                r_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_alu_kill && (r_addr[i] == alu_addr)) begin
                    r_vld[i] <= 1'b0;
                end
            end
            if (w_push) begin
                r_vld[r_wptr]  <= w_push_vld;
                r_addr[r_wptr] <= ld_addr;
                r_data[r_wptr] <= ld_data;
            end
        end
    end

    // FIFO pointers, occupancy and starvation counter
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_count  <= '0;
            r_starve <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count  <= r_count + c_CW'(w_push) - c_CW'(w_pop);
            r_starve <= w_starve_nxt;
        end
    end

    // Registered write port toward the register set; data holds when idle
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_rf_en <= '0;
            r_rf_d  <= '0;
        end else begin
            r_rf_en <= w_wr ? (32'd1 << w_wr_addr) : 32'd0;
            if (w_wr) r_rf_d <= w_wr_data;
        end
    end

`ifdef WB_BYPASS_EN
    // Early visibility of the value about to land in the register set
    always_comb begin
        byp_hit  = r_rf_en[byp_addr] && (byp_addr != 5'd0);
        byp_data = byp_hit ? r_rf_d : '0;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Scoreboard bench for regfile_wb_arbiter with a queue-based
//             reference model; directed scenarios followed by random traffic.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int c_DEPTH = 4;
    localparam int c_LIMIT = 8;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        alu_we = 1'b0;
    logic [4:0]  alu_addr = '0;
    logic [31:0] alu_data = '0;
    logic        alu_stall;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [4:0]  ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] rf_en;
    logic [31:0] rf_d;
    logic [2:0]  fifo_count;
    logic [4:0]  byp_addr = '0;
`ifdef WB_BYPASS_EN
    logic        byp_hit;
    logic [31:0] byp_data;
`endif

    regfile_wb_arbiter #(.DEPTH(c_DEPTH), .STARVE_LIMIT(c_LIMIT), .DATA_W(32)) dut (
        .clk(clk), .clr(clr),
        .alu_we(alu_we), .alu_addr(alu_addr), .alu_data(alu_data), .alu_stall(alu_stall),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
`ifdef WB_BYPASS_EN
        .byp_addr(byp_addr), .byp_hit(byp_hit), .byp_data(byp_data),
`endif
        .rf_en(rf_en), .rf_d(rf_d), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { bit v; bit [4:0] a; bit [31:0] d; } ent_t;
    typedef struct { bit [31:0] en; bit [31:0] d; int cnt; bit stall; bit ready;
                     bit bh; bit [31:0] bd; } exp_t;

    ent_t        mq[$];
    int          m_starve = 0;
    bit [31:0]   m_en = '0;
    bit [31:0]   m_d  = '0;
    exp_t        exq[$];

    function automatic void model_reset();
        mq.delete();
        m_starve = 0;
        m_en     = '0;
        m_d      = '0;
    endfunction

    function automatic exp_t model_view(input bit [4:0] ba);
        exp_t e;
        e.en    = m_en;
        e.d     = m_d;
        e.cnt   = mq.size();
        e.stall = (m_starve == c_LIMIT);
        e.ready = (mq.size() < c_DEPTH);
        e.bh    = m_en[ba] && (ba != 0);
        e.bd    = e.bh ? m_d : 32'd0;
        return e;
    endfunction

    // Applies one clock edge of the arbitration rules to the model
    function automatic void model_step(input bit we, input bit [4:0] aa, input bit [31:0] ad,
                                       input bit lv, input bit [4:0] la, input bit [31:0] ld);
        bit   stall = (m_starve == c_LIMIT);
        int   pre   = mq.size();
        bit   popped = 0;
        bit   wr = 0;
        bit   killer = 0;
        bit [4:0]  wa = '0;
        bit [31:0] wd = '0;
        ent_t e;
        if (stall) begin
            if (pre > 0) begin e = mq.pop_front(); popped = 1; wr = e.v; wa = e.a; wd = e.d; end
        end else if (we) begin
            if (aa != 0) begin
                wr = 1; wa = aa; wd = ad; killer = 1;
                foreach (mq[i]) if (mq[i].a == aa) mq[i].v = 0;
            end
        end else if (pre > 0) begin
            e = mq.pop_front(); popped = 1; wr = e.v; wa = e.a; wd = e.d;
        end
        if (lv && pre < c_DEPTH) begin
            e.v = (la != 0) && !(killer && la == aa);
            e.a = la;
            e.d = ld;
            mq.push_back(e);
        end
        if (popped || pre == 0) m_starve = 0;
        else if (m_starve < c_LIMIT) m_starve++;
        m_en = wr ? (32'd1 << wa) : 32'd0;
        if (wr) m_d = wd;
    endfunction

    // One stimulus cycle: drive inputs just after the edge, queue the expectation
    task automatic cycle(input bit rl, input bit we, input bit [4:0] aa, input bit [31:0] ad,
                         input bit lv, input bit [4:0] la, input bit [31:0] ld, input bit [4:0] ba);
        @(posedge clk);
        #1;
        alu_we = we; alu_addr = aa; alu_data = ad;
        ld_valid = lv; ld_addr = la; ld_data = ld; byp_addr = ba;
        if (rl) begin
            clr = 1'b0;
            model_reset();
            exq.push_back(model_view(ba));
        end else begin
            clr = 1'b1;
            exq.push_back(model_view(ba));
            model_step(we, aa, ad, lv, la, ld);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exq.size() > 0) begin
            exp_t e;
            e = exq.pop_front();
            chk("rf_en", rf_en, e.en);
            chk("rf_d", rf_d, e.d);
            chk("fifo_count", fifo_count, e.cnt);
            chk("alu_stall", alu_stall, e.stall);
            chk("ld_ready", ld_ready, e.ready);
`ifdef WB_BYPASS_EN
            chk("byp_hit", byp_hit, e.bh);
            chk("byp_data", byp_data, e.bd);
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        bit        hold_we;
        bit [4:0]  hold_a;
        bit [31:0] hold_d;
        model_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // Basic ALU write, then observe it with the bypass port pointed at it
        cycle(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 5);
        @(negedge clk);
        chk("basic rf_en", rf_en, 32'h20);
        chk("basic rf_d", rf_d, 32'hDEADBEEF);

        // Write to register 0 is suppressed, data holds
        cycle(0, 1, 0, 32'h1234, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("r0 rf_en", rf_en, 32'h0);
        chk("r0 rf_d", rf_d, 32'hDEADBEEF);

        // Fill the FIFO under continuous ALU traffic until starvation forces a pop
        for (int i = 1; i <= 4; i++) cycle(0, 1, 20, 32'h100 + i, 1, i[4:0], 32'h200 + i, 0);
        for (int i = 0; i < 30; i++) cycle(0, 1, 21, 32'h300 + i, 1, 9, 32'h400 + i, 0);
        idle(8);

        // WAW: queued load to r7 is superseded by a later ALU write to r7
        cycle(0, 0, 0, 0, 1, 7, 32'hAAAA, 0);
        cycle(0, 1, 7, 32'hBBBB, 0, 0, 0, 0);
        idle(4);
        // Same-cycle enqueue to the ALU target is killed too
        cycle(0, 1, 12, 32'hCCCC, 1, 12, 32'hDDDD, 12);
        idle(4);

        // Streaming through the FIFO wraps the pointers
        for (int i = 1; i <= 10; i++) cycle(0, 0, 0, 0, 1, i[4:0], 32'h5000 + i, 0);
        idle(4);

        // Reset with writes still queued
        for (int i = 1; i <= 3; i++) cycle(0, 1, 30, 32'h600 + i, 1, i[4:0], 32'h700 + i, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("midrst rf_en", rf_en, 32'h0);
        chk("midrst count", fifo_count, 3'd0);
        idle(6);

        // Random traffic; the ALU holds its request while stalled
        hold_we = 0; hold_a = 0; hold_d = 0;
        for (int i = 0; i < 1500; i++) begin
            if (m_starve != c_LIMIT) begin
                hold_we = ($urandom_range(0, 9) < 6);
                hold_a  = 5'($urandom_range(0, 7));
                hold_d  = $urandom;
            end
            cycle(0, hold_we, hold_a, hold_d, $urandom_range(0, 1) == 1,
                  5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)));
        end
        idle(10);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard drained", exq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
